pipe_stage_reg: RTL and testbench

// - Parametrised inter-stage pipeline register for the 5-stage MIPS core (D/E, E/M, M/W).
// - Carries instruction, PC, N operand channels, control word, exception code and branch-delay flag.
// - Priority: Reset > exception flush (Req) > freeze (Hold) > bubble insertion (Bubble) > load.
// - Saturating Tnew decrement on output; first-exception-wins merge; saturating bubble counter for perf/debug.

---
 rtl/pipe_stage_reg_pkg.sv | 43 ++++
 rtl/pipe_stage_reg_sat_dec.sv | 21 ++
 rtl/pipe_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: constants and types shared by the pipeline registers
//   and the hazard unit of the 5-stage MIPS core.
//
// Contents:
//   - exception codes (EXC_NONE = 0 means "no exception")
//   - control-word field positions (Tnew, Tuse)
//   - default reset PC and counter width
//   - stage_act_t: decoded per-cycle action of a pipeline register
package pipe_stage_reg_pkg;

    // Exception codes (CP0 Cause.ExcCode encoding)
    localparam int EXC_W_DEF = 5;
    localparam logic [EXC_W_DEF-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W_DEF-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W_DEF-1:0] EXC_SYS  = 5'd8;
    localparam logic [EXC_W_DEF-1:0] EXC_BP   = 5'd9;
    localparam logic [EXC_W_DEF-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W_DEF-1:0] EXC_OV   = 5'd12;

    // Control word layout
    localparam int CTRL_W_DEF = 31;
    localparam int TNEW_LSB   = 8;
    localparam int TNEW_W     = 3;
    localparam int TUSE_LSB   = TNEW_LSB + TNEW_W;
    localparam int TUSE_W     = 2;

    // Datapath defaults
    localparam int              DATA_W_DEF   = 32;
    localparam int              NUM_OPND_DEF = 2;
    localparam logic [31:0]     RESET_PC_DEF = 32'h0000_3000;
    localparam int              CNT_W_DEF    = 16;

    // What a pipeline register does on the next clock edge.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } stage_act_t;

endpackage

// File: rtl/pipe_stage_reg_sat_dec.sv
// sat_dec: W-bit saturating decrement, y = (a == 0) ? 0 : a - 1.
//   Used on the Tnew field of pipeline registers and by the hazard unit.
//
// Ports:
//   a  in  W  value to decrement
//   y  out W  decremented value, clamped at 0
module sat_dec #(
    parameter int W = 3
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    always_comb begin
        y = a;
        if (a != '0) begin
            y = a - 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register (D/E, E/M, M/W) carrying
//   instruction, PC, operand channels, control word, exception and BD flag.
//
// Ports:
//   Clk, Reset             clock (rising edge), synchronous active-high reset
//   Req                    exception flush, Hold freeze, Bubble insert NOP
//   InsIn/PCIn/OpndIn      instruction, PC, operands (channel k at [k*DATA_W +: DATA_W])
//   CtrlIn, BDIn           control word, branch-delay flag
//   UpExcIn/StageExcIn     upstream / current-stage exception codes
//   InsOut..BDOut          registered values; CtrlOut has Tnew pre-decremented
//   ExcOut, ValidOut       registered exception, 1 = real instruction
//   BubbleCnt              saturating count of bubbles since Reset
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                NUM_OPND = NUM_OPND_DEF,
    parameter int                CTRL_W   = CTRL_W_DEF,
    parameter int                TNEW_LSB = pipe_stage_reg_pkg::TNEW_LSB,
    parameter int                TNEW_W   = pipe_stage_reg_pkg::TNEW_W,
    parameter int                EXC_W    = EXC_W_DEF,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF),
    parameter int                CNT_W    = CNT_W_DEF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Req,
    input  logic                       Hold,
    input  logic                       Bubble,
    input  logic [DATA_W-1:0]          InsIn,
    input  logic [DATA_W-1:0]          PCIn,
    input  logic [NUM_OPND*DATA_W-1:0] OpndIn,
    input  logic [CTRL_W-1:0]          CtrlIn,
    input  logic [EXC_W-1:0]           UpExcIn,
    input  logic [EXC_W-1:0]           StageExcIn,
    input  logic                       BDIn,
    output logic [DATA_W-1:0]          InsOut,
    output logic [DATA_W-1:0]          PCOut,
    output logic [NUM_OPND*DATA_W-1:0] OpndOut,
    output logic [CTRL_W-1:0]          CtrlOut,
    output logic                       BDOut,
    output logic [EXC_W-1:0]           ExcOut,
    output logic                       ValidOut,
    output logic [CNT_W-1:0]           BubbleCnt
);

    stage_act_t act;

    logic [DATA_W-1:0] ins_q;
    logic [DATA_W-1:0] pc_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [EXC_W-1:0]  exc_q;
    logic              bd_q;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [EXC_W-1:0]  exc_merged;
    logic [TNEW_W-1:0] tnew_dec;

    // Priority: Reset > Req > Hold > Bubble > load
    always_comb begin
        act = ACT_LOAD;
        if (Reset) begin
            act = ACT_RESET;
        end else if (Req) begin
            act = ACT_FLUSH;
        end else if (Hold) begin
            act = ACT_HOLD;
        end else if (Bubble) begin
            act = ACT_BUBBLE;
        end
    end

    // The older (upstream) exception wins over one raised in this stage.
    assign exc_merged = (UpExcIn != '0) ? UpExcIn : StageExcIn;

    always_ff @(posedge Clk) begin
        unique case (act)
            ACT_RESET, ACT_FLUSH: begin
                ins_q   <= '0;
                pc_q    <= RESET_PC;
                ctrl_q  <= '0;
                exc_q   <= '0;
                bd_q    <= 1'b0;
                valid_q <= 1'b0;
            end
            ACT_HOLD: begin
                ins_q   <= ins_q;
                pc_q    <= pc_q;
                ctrl_q  <= ctrl_q;
                exc_q   <= exc_q;
                bd_q    <= bd_q;
                valid_q <= valid_q;
            end
            ACT_BUBBLE: begin
                // PC and BD follow the bubble so EPC/BD stay correct
                // if an interrupt is taken on it.
                ins_q   <= '0;
                pc_q    <= PCIn;
                ctrl_q  <= '0;
                exc_q   <= '0;
                bd_q    <= BDIn;
                valid_q <= 1'b0;
            end
            default: begin
                ins_q   <= InsIn;
                pc_q    <= PCIn;
                ctrl_q  <= CtrlIn;
                exc_q   <= exc_merged;
                bd_q    <= BDIn;
                valid_q <= 1'b1;
            end
        endcase
    end

    // Bubble counter: cleared only by Reset, kept across flushes.
    always_ff @(posedge Clk) begin
        if (act == ACT_RESET) begin
            cnt_q <= '0;
        end else if (act == ACT_BUBBLE && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // One register per operand channel.
    for (genvar k = 0; k < NUM_OPND; k++) begin : g_opnd
        logic [DATA_W-1:0] opnd_q;

        always_ff @(posedge Clk) begin
            unique case (act)
                ACT_RESET, ACT_FLUSH, ACT_BUBBLE: opnd_q <= '0;
                ACT_HOLD:                         opnd_q <= opnd_q;
                default: opnd_q <= OpndIn[k*DATA_W +: DATA_W];
            endcase
        end

        assign OpndOut[k*DATA_W +: DATA_W] = opnd_q;
    end

    // Tnew counts down by one per stage; the next stage sees it already
    // decremented, clamped at 0.
    sat_dec #(
        .W (TNEW_W)
    ) u_tnew_dec (
        .a (ctrl_q[TNEW_LSB +: TNEW_W]),
        .y (tnew_dec)
    );

    always_comb begin
        CtrlOut = ctrl_q;
        CtrlOut[TNEW_LSB +: TNEW_W] = tnew_dec;
    end

    assign InsOut    = ins_q;
    assign PCOut     = pc_q;
    assign BDOut     = bd_q;
    assign ExcOut    = exc_q;
    assign ValidOut  = valid_q;
    assign BubbleCnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
//   A second instance with a 4-bit bubble counter covers saturation.
module tb_pipe_stage_reg;

    logic        Clk = 1'b0;
    logic        Reset, Req, Hold, Bubble, BDIn;
    logic [31:0] InsIn, PCIn;
    logic [63:0] OpndIn;
    logic [30:0] CtrlIn;
    logic [4:0]  UpExcIn, StageExcIn;

    logic [31:0] InsOut, PCOut;
    logic [63:0] OpndOut;
    logic [30:0] CtrlOut;
    logic        BDOut, ValidOut;
    logic [4:0]  ExcOut;
    logic [15:0] BubbleCnt;

    logic [31:0] s_ins, s_pc;
    logic [63:0] s_opnd;
    logic [30:0] s_ctrl;
    logic        s_bd, s_valid;
    logic [4:0]  s_exc;
    logic [3:0]  s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg u_dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Hold(Hold),
        .Bubble(Bubble), .InsIn(InsIn), .PCIn(PCIn),
        .OpndIn(OpndIn), .CtrlIn(CtrlIn), .UpExcIn(UpExcIn),
        .StageExcIn(StageExcIn), .BDIn(BDIn),
        .InsOut(InsOut), .PCOut(PCOut), .OpndOut(OpndOut),
        .CtrlOut(CtrlOut), .BDOut(BDOut), .ExcOut(ExcOut),
        .ValidOut(ValidOut), .BubbleCnt(BubbleCnt)
    );

    pipe_stage_reg #(.CNT_W(4)) u_sat (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Hold(Hold),
        .Bubble(Bubble), .InsIn(InsIn), .PCIn(PCIn),
        .OpndIn(OpndIn), .CtrlIn(CtrlIn), .UpExcIn(UpExcIn),
        .StageExcIn(StageExcIn), .BDIn(BDIn),
        .InsOut(s_ins), .PCOut(s_pc), .OpndOut(s_opnd),
        .CtrlOut(s_ctrl), .BDOut(s_bd), .ExcOut(s_exc),
        .ValidOut(s_valid), .BubbleCnt(s_cnt)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Req = 1'b0; Hold = 1'b0; Bubble = 1'b0;
        InsIn = '0; PCIn = '0; OpndIn = '0; CtrlIn = '0;
        UpExcIn = '0; StageExcIn = '0; BDIn = 1'b0;

        // Reset
        tick();
        Reset = 1'b0;
        check("rst_pc",    PCOut,     32'h3000);
        check("rst_ctrl",  CtrlOut,   31'h0);
        check("rst_valid", ValidOut,  1'b0);
        check("rst_cnt",   BubbleCnt, 16'd0);
        check("rst_exc",   ExcOut,    5'd0);
        check("rst_ins",   InsOut,    32'h0);
        check("rst_bd",    BDOut,     1'b0);

        // Load with Tnew = 2
        InsIn  = 32'h8C01_0004;
        PCIn   = 32'h3008;
        CtrlIn = 31'h0123_4205;
        OpndIn = {32'hBBBB_0002, 32'hAAAA_0001};
        tick();
        check("ld_ins",   InsOut,   32'h8C01_0004);
        check("ld_pc",    PCOut,    32'h3008);
        check("ld_valid", ValidOut, 1'b1);
        check("ld_ctrl",  CtrlOut,  31'h0123_4105);
        check("ld_opnd",  OpndOut,  64'hBBBB_0002_AAAA_0001);
        check("ld_exc",   ExcOut,   5'd0);

        // Tnew = 0 stays 0; Tnew = 7 becomes 6
        CtrlIn = 31'h0123_4005;
        tick();
        check("tnew0", CtrlOut, 31'h0123_4005);
        CtrlIn = 31'h4000_0700;
        tick();
        check("tnew7", CtrlOut, 31'h4000_0600);

        // Bubble for 3 cycles; exception input must be dropped
        Bubble = 1'b1; PCIn = 32'h3010; BDIn = 1'b1;
        UpExcIn = 5'd4;
        tick(3);
        check("bub_ins",   InsOut,    32'h0);
        check("bub_valid", ValidOut,  1'b0);
        check("bub_pc",    PCOut,     32'h3010);
        check("bub_bd",    BDOut,     1'b1);
        check("bub_cnt",   BubbleCnt, 16'd3);
        check("bub_ctrl",  CtrlOut,   31'h0);
        check("bub_opnd",  OpndOut,   64'h0);
        check("bub_exc",   ExcOut,    5'd0);

        // Hold over Bubble
        Bubble = 1'b0; UpExcIn = '0;
        InsIn = 32'h0022_1820; PCIn = 32'h3020;
        CtrlIn = 31'h0000_0300; BDIn = 1'b0;
        tick();
        check("hl_load", ValidOut, 1'b1);
        Hold = 1'b1; Bubble = 1'b1;
        InsIn = 32'hFFFF_FFFF; PCIn = 32'h3030; BDIn = 1'b1;
        CtrlIn = 31'h7FFF_FFFF;
        tick(4);
        check("hl_ins",   InsOut,    32'h0022_1820);
        check("hl_pc",    PCOut,     32'h3020);
        check("hl_ctrl",  CtrlOut,   31'h0000_0200);
        check("hl_valid", ValidOut,  1'b1);
        check("hl_bd",    BDOut,     1'b0);
        check("hl_cnt",   BubbleCnt, 16'd3);
        Hold = 1'b0;
        tick();
        check("hl_rel_ins",   InsOut,    32'h0);
        check("hl_rel_valid", ValidOut,  1'b0);
        check("hl_rel_pc",    PCOut,     32'h3030);
        check("hl_rel_bd",    BDOut,     1'b1);
        check("hl_rel_cnt",   BubbleCnt, 16'd4);

        // Exception merge
        Bubble = 1'b0; BDIn = 1'b0;
        InsIn = 32'h0000_000C; PCIn = 32'h3040; CtrlIn = '0;
        UpExcIn = 5'd4; StageExcIn = 5'd10;
        tick();
        check("exc_up", ExcOut, 5'd4);
        UpExcIn = 5'd0; StageExcIn = 5'd12;
        tick();
        check("exc_stage", ExcOut, 5'd12);

        // Req during Hold flushes, counter kept
        Hold = 1'b1; Req = 1'b1; Bubble = 1'b1;
        tick();
        Hold = 1'b0; Req = 1'b0; Bubble = 1'b0;
        check("req_exc",   ExcOut,    5'd0);
        check("req_pc",    PCOut,     32'h3000);
        check("req_valid", ValidOut,  1'b0);
        check("req_ins",   InsOut,    32'h0);
        check("req_cnt",   BubbleCnt, 16'd4);
        StageExcIn = '0;

        // Counter saturation on the 4-bit instance
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("sat_rst", s_cnt, 4'd0);
        Bubble = 1'b1;
        tick(10);
        check("sat_mid", s_cnt, 4'd10);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("sat_mid_rst",  s_cnt,     4'd0);
        check("main_mid_rst", BubbleCnt, 16'd0);
        tick(20);
        check("sat_full",  s_cnt,     4'd15);
        check("main_full", BubbleCnt, 16'd20);
        Bubble = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
